robot_nav_ctrl: RTL

ROBOT_NAV_CTRL -- requirements
Module: robot_nav_ctrl

---
 rtl/robot_nav_pkg.sv | 84 ++++++++
 rtl/sensor_debounce.sv | 49 ++++
 rtl/robot_nav_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/robot_nav_pkg.sv
// Shared definitions for the robot navigation controller.
//   - nav_state_e : FSM state encoding
//   - sens_t      : debounced sensor vector, bit0 E (left) .. bit3 A (rear)
//   - MOVE_*      : move output codes
//   - SEG_*       : active-high seven-segment patterns (bit0 = a .. bit6 = g)
//   - decide()    : priority decision on debounced sensors
//   - move_of() / seg_of() : per-state output lookup
package robot_nav_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_TURN_L = 3'd2,
        ST_TURN_R = 3'd3,
        ST_REV    = 3'd4,
        ST_STOP   = 3'd5
    } nav_state_e;

    // MSB first so that the struct overlays sen_in[3:0] directly.
    typedef struct packed {
        logic a;   // rear
        logic d;   // right
        logic f;   // front
        logic e;   // left
    } sens_t;

    localparam int NUM_SENS = 4;

    localparam logic [2:0] MOVE_IDLE   = 3'd0;
    localparam logic [2:0] MOVE_FWD    = 3'd1;
    localparam logic [2:0] MOVE_TURN_L = 3'd2;
    localparam logic [2:0] MOVE_TURN_R = 3'd3;
    localparam logic [2:0] MOVE_REV    = 3'd4;
    localparam logic [2:0] MOVE_STOP   = 3'd5;

    localparam logic [6:0] SEG_IDLE   = 7'b0000000;
    localparam logic [6:0] SEG_FWD    = 7'b1110001;  // "F"
    localparam logic [6:0] SEG_TURN_L = 7'b0111000;  // "L"
    localparam logic [6:0] SEG_TURN_R = 7'b1010000;  // "r"
    localparam logic [6:0] SEG_REV    = 7'b1110111;  // "A"
    localparam logic [6:0] SEG_STOP   = 7'b1101101;  // "S"

    // First free direction wins: front, left, right, rear, else stop.
    function automatic nav_state_e decide(input sens_t s);
        nav_state_e r;
        if (!s.f)      r = ST_FWD;
        else if (!s.e) r = ST_TURN_L;
        else if (!s.d) r = ST_TURN_R;
        else if (!s.a) r = ST_REV;
        else           r = ST_STOP;
        return r;
    endfunction

    function automatic logic is_hold_state(input nav_state_e st);
        return (st == ST_TURN_L) || (st == ST_TURN_R) || (st == ST_REV);
    endfunction

    function automatic logic [2:0] move_of(input nav_state_e st);
        logic [2:0] m;
        case (st)
            ST_FWD:    m = MOVE_FWD;
            ST_TURN_L: m = MOVE_TURN_L;
            ST_TURN_R: m = MOVE_TURN_R;
            ST_REV:    m = MOVE_REV;
            ST_STOP:   m = MOVE_STOP;
            default:   m = MOVE_IDLE;
        endcase
        return m;
    endfunction

    function automatic logic [6:0] seg_of(input nav_state_e st);
        logic [6:0] p;
        case (st)
            ST_FWD:    p = SEG_FWD;
            ST_TURN_L: p = SEG_TURN_L;
            ST_TURN_R: p = SEG_TURN_R;
            ST_REV:    p = SEG_REV;
            ST_STOP:   p = SEG_STOP;
            default:   p = SEG_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit synchroniser + debouncer.
//   clk, rst_n : clock, async active-low reset
//   raw_in     : asynchronous sensor bit
//   db_out     : debounced level; follows the synchronised input only after
//                it has disagreed for DEBOUNCE_CYCLES consecutive cycles
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic db_out
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter holds the number of mismatching cycles already seen; the
    // mismatch that finds it at CNT_LAST is the DEBOUNCE_CYCLES-th one.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) db_d  = sync2_q;
            else                   cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_out = db_q;

endmodule

// File: rtl/robot_nav_ctrl.sv
// Obstacle-avoiding navigation controller.
//   clk, rst_n : clock, async active-low reset
//   sen_in[3:0]: raw obstacle sensors (1 = obstacle), E/F/D/A = bit0..3
//   enable     : synchronous run enable; low forces IDLE
//   seg[6:0]   : registered seven-segment drive (bit0 = a)
//   move[2:0]  : registered move code
//   coll_cnt   : saturating count of entries into REV or STOP
module robot_nav_ctrl
    import robot_nav_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int CNT_W           = 8,
    parameter bit SEG_ACTIVE_LOW  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       sen_in,
    input  logic             enable,
    output logic [6:0]       seg,
    output logic [2:0]       move,
    output logic [CNT_W-1:0] coll_cnt
);

    localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [6:0]        SEG_POL   = {7{SEG_ACTIVE_LOW}};
    localparam logic [6:0]        SEG_RST   = SEG_IDLE ^ SEG_POL;

    logic [NUM_SENS-1:0] sen_db;

    for (genvar g = 0; g < NUM_SENS; g++) begin : g_db
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_in (sen_in[g]),
            .db_out (sen_db[g])
        );
    end

    nav_state_e        state_q, state_d, decision;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  coll_q, coll_d;
    logic [2:0]        move_q, move_d;
    logic [6:0]        seg_q, seg_d;
    logic              apply;
    logic              bump;

    // State register; outputs are registered alongside it from the same
    // next-state value so seg/move never lag the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            coll_q  <= '0;
            move_q  <= MOVE_IDLE;
            seg_q   <= SEG_RST;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            coll_q  <= coll_d;
            move_q  <= move_d;
            seg_q   <= seg_d;
        end
    end

    // Next state, hold counter and collision counter.
    always_comb begin
        decision = decide(sens_t'(sen_db));
        state_d  = state_q;
        hold_d   = hold_q;
        apply    = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FWD, ST_STOP: apply = 1'b1;
                ST_TURN_L, ST_TURN_R, ST_REV: begin
                    if (hold_q == '0) apply  = 1'b1;
                    else              hold_d = hold_q - HOLD_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
            if (apply) begin
                state_d = decision;
                // Re-entering the same hold state also reloads the counter.
                if (is_hold_state(decision)) hold_d = HOLD_LOAD;
            end
        end

        // A REV decision always counts (fresh entry or hold-expiry re-entry);
        // STOP re-applies every cycle, so only the entry edge counts.
        bump = apply && ((decision == ST_REV) ||
                         (decision == ST_STOP && state_q != ST_STOP));
        coll_d = coll_q;
        if (bump && (coll_q != {CNT_W{1'b1}})) coll_d = coll_q + CNT_W'(1);
    end

    // Output decode from the next state.
    always_comb begin
        move_d = move_of(state_d);
        seg_d  = seg_of(state_d) ^ SEG_POL;
    end

    assign seg      = seg_q;
    assign move     = move_q;
    assign coll_cnt = coll_q;

endmodule
